// File: rtl/mx_blk_dequant_pkg.sv
// Shared defaults and the output beat layout for the MX block dequantiser.
package mx_pkg;

   localparam int DEF_WIDTH_I    = 4;
   localparam int DEF_WIDTH_O    = 24;
   localparam int DEF_BLOCK_SIZE = 32;
   localparam int DEF_SCALE_W    = 8;

   // E8M0 reserves the all-ones exponent as NaN
   localparam logic [DEF_SCALE_W-1:0] NAN_SCALE = 8'hFF;

   typedef struct packed {
      logic [DEF_WIDTH_O-1:0] man;
      logic [DEF_SCALE_W-1:0] exp;
      logic                   last;
      logic                   nan;
   } beat_t;

endpackage

// File: rtl/mx_blk_dequant_pipe_stage.sv
// Single elastic register slice: full-throughput valid/ready with output hold under backpressure.
module mx_pipe_stage #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [width-1:0] up_data,
   output logic             dn_valid,
   input  logic             dn_ready,
   output logic [width-1:0] dn_data
);

   assign up_ready = ~dn_valid | dn_ready;

   // slot refills whenever it is empty or being drained this cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         dn_valid <= 1'b0;
         dn_data  <= '0;
      end else if (up_ready) begin
         dn_valid <= up_valid;
         if (up_valid) begin
            dn_data <= up_data;
         end
      end
   end

endmodule

// File: rtl/mx_blk_dequant.sv
// MX block dequantiser: left-aligns element mantissas and attaches the shared block exponent.
// Optional NaN-scale handling is enabled by defining MX_DEQ_NAN_EN.
module mx_blk_dequant
   import mx_pkg::*;
#(
   parameter int width_i    = DEF_WIDTH_I,
   parameter int width_o    = DEF_WIDTH_O,
   parameter int block_size = DEF_BLOCK_SIZE,
   parameter int scale_w    = DEF_SCALE_W
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [scale_w-1:0] i_scale,
   input  logic [width_i-1:0] i_elem,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [width_o-1:0] o_man,
   output logic [scale_w-1:0] o_exp,
   output logic               o_last,
   output logic               o_nan
);

   localparam int cnt_w  = (block_size > 1) ? $clog2(block_size) : 1;
   localparam int beat_w = width_o + scale_w + 2;
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(block_size - 1);

   logic [cnt_w-1:0]   cnt;
   logic [scale_w-1:0] scale_q;
   logic [scale_w-1:0] blk_scale;
   logic               in_xfer;
   logic               s1_ready;
   logic               s1_valid;
   logic               s2_ready;
   logic               s2_valid;
   logic [width_o-1:0] man_al;
   logic [width_o-1:0] man_d;
   logic [scale_w-1:0] exp_d;
   logic               last_d;
   logic               nan_d;
   logic [beat_w-1:0]  beat_d;
   logic [beat_w-1:0]  s1_data;
   logic [beat_w-1:0]  s2_data;

   assign o_ready = s1_ready & ~i_rst;
   assign in_xfer = i_valid & o_ready;

   // the first element of a block must see its own scale, not the stale register
   assign blk_scale = (cnt == '0) ? i_scale : scale_q;
   assign man_al    = width_o'(i_elem) << (width_o - width_i);
   assign last_d    = (cnt == cnt_last);

   // element position within the block and the captured block exponent
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt     <= '0;
         scale_q <= '0;
      end else if (in_xfer) begin
         cnt <= (cnt == cnt_last) ? '0 : cnt + 1'b1;
         if (cnt == '0) begin
            scale_q <= i_scale;
         end
      end
   end

   // element expansion; zero elements carry no exponent
   always_comb begin
      man_d = '0;
      exp_d = '0;
      nan_d = 1'b0;
      if (i_elem != '0) begin
         man_d = man_al;
         exp_d = blk_scale;
      end else begin
         man_d = '0;
         exp_d = '0;
      end
`ifdef MX_DEQ_NAN_EN
      if (blk_scale == {scale_w{1'b1}}) begin
         nan_d = 1'b1;
         man_d = '1;
         exp_d = blk_scale;
      end else begin
         nan_d = 1'b0;
      end
`else
      nan_d = 1'b0;
`endif
   end

   assign beat_d = {man_d, exp_d, last_d, nan_d};

   mx_pipe_stage #(.width(beat_w)) u_stage1 (
      .clk      (i_clk),
      .rst      (i_rst),
      .up_valid (i_valid),
      .up_ready (s1_ready),
      .up_data  (beat_d),
      .dn_valid (s1_valid),
      .dn_ready (s2_ready),
      .dn_data  (s1_data)
   );

   mx_pipe_stage #(.width(beat_w)) u_stage2 (
      .clk      (i_clk),
      .rst      (i_rst),
      .up_valid (s1_valid),
      .up_ready (s2_ready),
      .up_data  (s1_data),
      .dn_valid (s2_valid),
      .dn_ready (i_ready),
      .dn_data  (s2_data)
   );

   assign o_valid = s2_valid;
   assign o_man   = s2_data[beat_w-1 -: width_o];
   assign o_exp   = s2_data[scale_w+1 -: scale_w];
   assign o_last  = s2_data[1];
   assign o_nan   = s2_data[0];

endmodule

// File: tb/tb_mx_blk_dequant.sv
// Scoreboard bench for mx_blk_dequant; follows MX_DEQ_NAN_EN when computing expectations.
module tb_mx_blk_dequant;
   import mx_pkg::*;

   logic        clk = 1'b0;
   logic        i_rst, i_valid, o_ready, o_valid, i_ready, o_last, o_nan;
   logic [7:0]  i_scale, o_exp;
   logic [3:0]  i_elem;
   logic [23:0] o_man;

   always #5 clk = ~clk;

   mx_blk_dequant dut (
      .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_scale(i_scale), .i_elem(i_elem), .o_valid(o_valid), .i_ready(i_ready),
      .o_man(o_man), .o_exp(o_exp), .o_last(o_last), .o_nan(o_nan)
   );

   beat_t      sb[$];
   int         cmp_cnt = 0;
   int         err_cnt = 0;
   int         bcnt = 0;
   logic [7:0] bscale = 8'h00;
   int         rdy_mode = 0;
   int         ncyc = 0;
   int         first_in = -1;
   int         first_out = -1;
   int         out_cnt = 0;
   bit         started = 1'b0;

   function automatic beat_t model(input logic [3:0] e, input logic [7:0] s, input bit last);
      beat_t b;
      b.man  = {e, 20'h00000};
      b.exp  = s;
      b.last = last;
      b.nan  = 1'b0;
      if (e == 4'h0) begin
         b.man = 24'h000000;
         b.exp = 8'h00;
      end
`ifdef MX_DEQ_NAN_EN
      if (s == NAN_SCALE) begin
         b.nan = 1'b1;
         b.man = 24'hFFFFFF;
         b.exp = s;
      end
`endif
      return b;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      cmp_cnt++;
      assert (got === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // downstream ready pattern: constant 1, or 1,0,0,1 repeating
   initial begin
      logic [3:0] pat;
      int ph;
      pat = 4'b1001;
      ph = 0;
      i_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ph++;
         i_ready = (rdy_mode == 0) ? 1'b1 : pat[ph % 4];
      end
   end

   // output monitor: ready rule against modelled occupancy, then scoreboard pop
   always @(negedge clk) begin
      beat_t e;
      ncyc++;
      if (started) begin
         chk("o_ready_rule", {63'd0, o_ready}, {63'd0, (!i_rst && !(sb.size() == 2 && !i_ready))});
         if (!i_rst && i_valid && o_ready && first_in < 0) first_in = ncyc;
         if (!i_rst && o_valid === 1'b1 && first_out < 0) first_out = ncyc;
         if (!i_rst && o_valid === 1'b1 && i_ready) begin
            cmp_cnt++;
            assert (sb.size() != 0) else begin
               err_cnt++;
               $error("FAIL sb_underflow observed=extra_output expected=none");
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("beat", {30'd0, o_man, o_exp, o_last, o_nan}, {30'd0, e});
               out_cnt++;
            end
         end
      end
   end

   task automatic send(input logic [3:0] e, input logic [7:0] s);
      bit acc;
      int t;
      i_valid = 1'b1;
      i_elem  = e;
      i_scale = s;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 100) begin
         @(negedge clk);
         acc = o_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (acc) begin
         if (bcnt == 0) bscale = s;
         sb.push_back(model(e, bscale, bcnt == 31));
         bcnt = (bcnt == 31) ? 0 : bcnt + 1;
      end
      cmp_cnt++;
      assert (acc) else begin
         err_cnt++;
         $error("FAIL send_timeout observed=not_accepted expected=accepted");
      end
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int t;
      i_valid = 1'b0;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int base;
      i_rst = 1'b1; i_valid = 1'b0; i_elem = 4'h0; i_scale = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      started = 1'b1;
      @(negedge clk);
      chk("rst_outputs", {28'd0, o_valid, o_ready, o_last, o_nan, o_man, o_exp}, 64'd0);
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", {63'd0, o_ready}, 64'd1);
      @(posedge clk);
      #1;

      // block of 3s, scale only taken from the first element
      base = out_cnt; first_in = -1; first_out = -1;
      send(4'h3, 8'd127);
      for (int i = 0; i < 31; i++) send(4'h3, 8'd5);
      drain();
      chk("blk1_count", 64'(out_cnt - base), 64'd32);
      chk("latency", 64'(first_out - first_in), 64'd2);

      // zero, sign-extreme values and mid-block gaps
      base = out_cnt;
      send(4'h0, 8'd127);
      send(4'h8, 8'd1);
      send(4'hF, 8'd2);
      idle(3);
      send(4'h1, 8'd3);
      send(4'h7, 8'd4);
      for (int i = 5; i < 32; i++) send(4'(i % 16), 8'd9);
      drain();
      chk("blk2_count", 64'(out_cnt - base), 64'd32);

      // all-ones scale block then an ordinary one
      send(4'h0, 8'hFF);
      send(4'h5, 8'h01);
      for (int i = 2; i < 32; i++) send(4'(i % 16), 8'h02);
      send(4'h0, 8'd10);
      send(4'h5, 8'hFF);
      for (int i = 2; i < 32; i++) send(4'((i * 3) % 16), 8'd11);
      drain();

      // backpressure pattern over two blocks
      base = out_cnt;
      rdy_mode = 1;
      for (int i = 0; i < 64; i++) send(4'((i % 15) + 1), (i == 0) ? 8'd33 : 8'd44);
      drain();
      rdy_mode = 0;
      chk("bp_count", 64'(out_cnt - base), 64'd64);

      // reset after element index 10 of a block
      for (int i = 0; i <= 10; i++) send(4'(i + 2), 8'd9);
      i_valid = 1'b0;
      i_rst = 1'b1;
      sb.delete();
      bcnt = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      i_rst = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", {63'd0, o_valid}, 64'd0);
      @(posedge clk);
      #1;
      base = out_cnt;
      send(4'h6, 8'd20);
      for (int i = 1; i < 32; i++) send(4'((i % 7) + 1), 8'd3);
      drain();
      chk("post_rst_count", 64'(out_cnt - base), 64'd32);

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/mx_blk_dequant.md
MX_BLK_DEQUANT -- requirements
Module: mx_blk_dequant

Interface
REQ-001 Parameter width_i, default 4: bit width of an incoming element mantissa.
REQ-002 Parameter width_o, default 24: bit width of the expanded output mantissa; SHALL satisfy width_o >= width_i.
REQ-003 Parameter block_size, default 32: number of elements that share one scale.
REQ-004 Parameter scale_w, default 8: bit width of the shared scale (E8M0) exponent.
REQ-005 i_clk  input  1  clock; all logic SHALL be clocked on its rising edge.
REQ-006 i_rst  input  1  reset; synchronous, active-high.
REQ-007 i_valid  input  1  an element is presented on i_elem.
REQ-008 o_ready  output  1  the block accepts i_elem this cycle.
REQ-009 i_scale  input  scale_w  shared block exponent; sampled only on the first element of a block.
REQ-010 i_elem  input  width_i  two's-complement element mantissa.
REQ-011 o_valid  output  1  output fields are valid.
REQ-012 i_ready  input  1  downstream accepts the output this cycle.
REQ-013 o_man  output  width_o  expanded mantissa.
REQ-014 o_exp  output  scale_w  exponent associated with o_man.
REQ-015 o_last  output  1  marks the final element (index block_size-1) of a block.
REQ-016 o_nan  output  1  block scale is NaN.

Function
REQ-017 Input transfer SHALL occur when i_valid and o_ready are both 1; output transfer SHALL occur when o_valid and i_ready are both 1.
REQ-018 Element counter SHALL advance by 1 per input transfer, wrap from block_size-1 to 0, and hold otherwise.
REQ-019 On a transfer with counter 0, i_scale SHALL be captured into the block scale register; on other transfers i_scale SHALL be ignored.
REQ-020 o_man SHALL be i_elem left-aligned: i_elem in bits [width_o-1 : width_o-width_i], lower bits 0.
REQ-021 o_exp SHALL equal the captured block scale, except that an element value of 0 SHALL produce o_man=0 and o_exp=0.
REQ-022 o_last SHALL be 1 exactly for the element whose counter value at input transfer was block_size-1.
REQ-023 Datapath SHALL be a two-stage elastic pipeline: latency 2 cycles from input transfer to o_valid with i_ready held at 1, throughput 1 element per cycle.
REQ-024 o_ready SHALL be 1 unless both stages hold data and i_ready is 0; no element SHALL be dropped or duplicated under any i_ready pattern.
REQ-025 Output fields SHALL remain stable while o_valid=1 and i_ready=0.
REQ-026 Simultaneous input and output transfer with a full pipeline SHALL keep occupancy unchanged.

Reset
REQ-027 While i_rst=1: o_valid=0, o_last=0, o_nan=0, o_man=0, o_exp=0, counter=0, scale register=0, o_ready=0.
REQ-028 Reset asserted mid-block SHALL discard in-flight elements; the first transfer after reset SHALL be treated as counter 0.
REQ-029 o_ready SHALL be 1 in the first cycle after i_rst deasserts.

Configuration
REQ-030 Macro MX_DEQ_NAN_EN defined: a captured scale of all ones SHALL set o_nan=1 and o_man all ones for every element of that block, including zero elements.
REQ-031 Macro MX_DEQ_NAN_EN undefined: o_nan SHALL be tied 0, and a scale of all ones SHALL be treated as an ordinary exponent.

Structure
REQ-032 Package mx_pkg SHALL hold the default scale_w, block_size and NaN-scale constant, and a typedef for the output beat struct (man, exp, last, nan).
REQ-033 The pipeline register slice with valid/ready SHALL be the sub-module mx_pipe_stage, instantiated twice.

Verification
REQ-034 Reset, then 32 elements 4'h3 with i_scale=8'd127 on the first and i_scale=8'd5 on the rest, i_ready=1 -> 32 outputs o_man=24'h300000, o_exp=127, o_last=1 only on the 32nd, first o_valid 2 cycles after first transfer.
REQ-035 Element 4'h0 with scale 127 -> o_man=0, o_exp=0.
REQ-036 i_ready toggling 1,0,0,1 repeating while i_valid=1 continuously over 64 elements -> output sequence identical to input order, no loss or duplication, o_ready=0 only when both stages are full.
REQ-037 MX_DEQ_NAN_EN defined, block scale 8'hFF, elements 4'h0 and 4'h5 -> o_nan=1, o_man=24'hFFFFFF for both; next block with scale 8'd10 -> o_nan=0.
REQ-038 i_rst pulsed after element 10 of a block, then new block with scale 8'd20 -> outputs before reset are discarded, first new output o_exp=20, o_last on its 32nd element.
